// File: rtl/elastic_fifo_pkg.sv
// ----------------------------------------------------------------------------
// elastic_fifo_pkg
//   Shared helpers for the elastic FIFO used on CGRA interconnect/PE ports.
//   The only content is an elaboration-time sanity check for the FIFO depth.
//   This package adds no typedefs.
//
//   Contents
//     MIN_DEPTH  smallest legal FIFO depth
//     is_pow2()  returns 1 when the argument is a non-zero power of two
// ----------------------------------------------------------------------------
package elastic_fifo_pkg;

    localparam int MIN_DEPTH = 2;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage : elastic_fifo_pkg

// File: rtl/elastic_fifo_mem.sv
// ----------------------------------------------------------------------------
// elastic_fifo_mem
//   Storage array for elastic_fifo. It holds DEPTH words of DATA_WIDTH bits in
//   flops. It has one synchronous write port and one asynchronous read port.
//   Reset and clear both zero every entry, so the head word reads as 0 after
//   either one.
//
//   Ports
//     clk_i    in   1           clock, rising edge
//     rst_ni   in   1           asynchronous active-low reset, zeroes storage
//     clr_i    in   1           synchronous clear, zeroes storage, beats we_i
//     we_i     in   1           write enable
//     waddr_i  in   AW          write address
//     wdata_i  in   DATA_WIDTH  write data
//     raddr_i  in   AW          read address
//     rdata_o  out  DATA_WIDTH  read data (combinational from raddr_i)
// ----------------------------------------------------------------------------
module elastic_fifo_mem #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
        end else if (clr_i) begin
            mem_q <= '{default: '0};
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : elastic_fifo_mem

// File: rtl/elastic_fifo.sv
// ----------------------------------------------------------------------------
// elastic_fifo
//   Parametrised elastic FIFO, DEPTH entries deep. It sits between PE outputs
//   and switch inputs where more than two slots of slack are needed. Both
//   sides use valid/ready. din_r_o depends only on state and en_i, so no
//   combinational path exists from dout_r_i to din_r_o.
//
//   Build option
//     ELASTIC_FIFO_BYPASS_EN  When defined, an empty FIFO forwards din_i to
//                             dout_o in the same cycle. If dout_r_i is also
//                             high, the word is consumed and never written.
//                             This adds a din_v_i -> dout_v_o combinational
//                             path. When undefined, the outputs come only
//                             from registered state (1-cycle minimum latency).
//
//   Ports
//     clk_i     in   1           clock, rising edge
//     rst_ni    in   1           asynchronous active-low reset
//     clr_i     in   1           synchronous clear, priority over en_i
//     en_i      in   1           global enable; 0 freezes all state
//     din_i     in   DATA_WIDTH  input payload
//     din_v_i   in   1           input valid
//     din_r_o   out  1           input ready
//     dout_o    out  DATA_WIDTH  output payload (head entry)
//     dout_v_o  out  1           output valid
//     dout_r_i  in   1           output ready
//     count_o   out  CNT_W       occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module elastic_fifo
    import elastic_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  din_v_i,
    output logic                  din_r_o,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_v_o,
    input  logic                  dout_r_i,
    output logic [CNT_W-1:0]      count_o
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (!is_pow2(DEPTH) || (DEPTH < MIN_DEPTH)) begin : g_depth_check
        $error("elastic_fifo: DEPTH=%0d must be a power of two and >= 2", DEPTH);
    end

    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  live_q;
    logic                  not_full;
    logic                  not_empty;
    logic                  push;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] head;

    // live_q stays low while reset is asserted and for the first edge after
    // reset is released. This keeps din_r_o low during reset without a
    // combinational path from rst_ni to an output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    assign not_full  = (count_q != FULL_CNT);
    assign not_empty = (count_q != '0);

    // When full, din_r_o is low even if a pop happens this cycle. A pop
    // therefore never frees a slot for a push in the same cycle, and ready
    // does not depend on dout_r_i.
    assign din_r_o = en_i & live_q & not_full;

`ifdef ELASTIC_FIFO_BYPASS_EN
    logic byp_active;
    logic byp_take;

    assign byp_active = en_i & live_q & ~not_empty;
    assign byp_take   = byp_active & din_v_i & dout_r_i;

    assign dout_v_o = (en_i & live_q & not_empty) | (byp_active & din_v_i);
    assign dout_o   = byp_active ? din_i : head;

    // A word consumed through the bypass never touches storage.
    assign rd_en = en_i & live_q & not_empty & dout_r_i;
    assign push  = din_v_i & din_r_o & ~byp_take;
`else
    assign dout_v_o = en_i & live_q & not_empty;
    assign dout_o   = head;
    assign rd_en    = dout_v_o & dout_r_i;
    assign push     = din_v_i & din_r_o;
`endif

    // Both pointers are AW bits wide and wrap from DEPTH-1 to 0 on their own.
    // count_q tells full from empty when the pointers are equal.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;

    elastic_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (din_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

endmodule : elastic_fifo

// File: tb/tb_elastic_fifo.sv
// ----------------------------------------------------------------------------
// tb_elastic_fifo
//   Self-checking bench for elastic_fifo (DEPTH=4, DATA_WIDTH=32).
//   A queue holds the words accepted by the FIFO. Occupancy, ready and valid
//   are predicted from the queue length. Every word the FIFO delivers is
//   compared with the front of the queue.
// ----------------------------------------------------------------------------
module tb_elastic_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          en;
    logic [DW-1:0] din;
    logic          din_v;
    logic          din_r;
    logic [DW-1:0] dout;
    logic          dout_v;
    logic          dout_r;
    logic [CW-1:0] count;

    int            n_vec  = 0;
    int            n_miss = 0;
    logic [DW-1:0] sb_q[$];

    elastic_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (clr),
        .en_i     (en),
        .din_i    (din),
        .din_v_i  (din_v),
        .din_r_o  (din_r),
        .dout_o   (dout),
        .dout_v_o (dout_v),
        .dout_r_i (dout_r),
        .count_o  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // This task starts at a negedge, after the inputs have been set. It
    // samples the outputs 2 time units later, in the low phase of the clock.
    // It then updates the model and returns at the next negedge.
    task automatic cycle();
        int            sz;
        bit            exp_dr;
        bit            exp_dv;
        bit            do_push;
        bit            do_pop;
        logic [DW-1:0] exp_w;
        #2;
        sz     = sb_q.size();
        exp_dr = en && (sz != DEPTH);
`ifdef ELASTIC_FIFO_BYPASS_EN
        exp_dv = en && ((sz != 0) || din_v);
`else
        exp_dv = en && (sz != 0);
`endif
        check_val("count", 64'(count), 64'(sz));
        check_val("din_r", 64'(din_r), 64'(exp_dr));
        check_val("dout_v", 64'(dout_v), 64'(exp_dv));
        if (clr) begin
            sb_q.delete();
        end else begin
            do_push = din_v && exp_dr;
            do_pop  = exp_dv && dout_r;
            if (do_pop) begin
                exp_w = (sz == 0) ? din : sb_q[0];
                check_val("dout", 64'(dout), 64'(exp_w));
                if (sz != 0) void'(sb_q.pop_front());
            end
            if (do_push && !(do_pop && sz == 0)) sb_q.push_back(din);
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit e, input bit v, input logic [DW-1:0] d, input bit r);
        en     = e;
        din_v  = v;
        din    = d;
        dout_r = r;
    endtask

    initial begin
        rst_n  = 1'b0;
        clr    = 1'b0;
        set_in(1'b1, 1'b0, '0, 1'b0);

        // Reset state, sampled while reset is held.
        @(negedge clk);
        @(negedge clk);
        #2;
        check_val("rst_din_r", 64'(din_r), 64'd0);
        check_val("rst_dout_v", 64'(dout_v), 64'd0);
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_dout", 64'(dout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check_val("post_rst_din_r", 64'(din_r), 64'd1);
        @(negedge clk);

        // Fill to DEPTH with the output stalled. Offer a 5th word, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 1'b1, 32'hA0 + 32'(i), 1'b0);
            cycle();
        end
        check_val("fill_count", 64'(count), 64'd4);
        check_val("fill_din_r", 64'(din_r), 64'd0);
        set_in(1'b1, 1'b1, 32'hA4, 1'b0);
        cycle();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b1);
            cycle();
        end
        check_val("drain_count", 64'(count), 64'd0);

        // Stream 100 incrementing words.
        for (int i = 0; i < 100; i++) begin
            set_in(1'b1, 1'b1, 32'h1000 + 32'(i), 1'b1);
            cycle();
        end
        set_in(1'b1, 1'b0, '0, 1'b1);
        cycle();

        // Full with a pop and a push offered: the pop happens, the push does not.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 1'b1, 32'hB0 + 32'(i), 1'b0);
            cycle();
        end
        set_in(1'b1, 1'b1, 32'hBF, 1'b1);
        cycle();
        check_val("full_pop_count", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b1);
            cycle();
        end

        // Drop en_i for 3 cycles with count=2.
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b1, 32'hC0 + 32'(i), 1'b0);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 32'hCF, 1'b1);
            #1;
            check_val("en_low_head", 64'(dout), 64'(sb_q[0]));
            #1;
            cycle();
        end
        check_val("en_low_count", 64'(count), 64'd2);
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b1);
            cycle();
        end

        // Clear with count=3 and a push in the same cycle.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 32'hD0 + 32'(i), 1'b0);
            cycle();
        end
        clr = 1'b1;
        set_in(1'b1, 1'b1, 32'hDD, 1'b0);
        cycle();
        clr = 1'b0;
        check_val("clr_count", 64'(count), 64'd0);
        check_val("clr_dout_v", 64'(dout_v), 64'd0);
        set_in(1'b1, 1'b0, '0, 1'b1);
        cycle();

`ifdef ELASTIC_FIFO_BYPASS_EN
        // The bypass passes a word through an empty FIFO in the same cycle.
        set_in(1'b1, 1'b1, 32'h55, 1'b1);
        #1;
        check_val("byp_dout", 64'(dout), 64'h55);
        #1;
        cycle();
        check_val("byp_count", 64'(count), 64'd0);
        set_in(1'b1, 1'b0, '0, 1'b0);
        cycle();
`endif

        // Reset asserted mid-transfer discards the stored words.
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b1, 32'hE0 + 32'(i), 1'b0);
            cycle();
        end
        rst_n = 1'b0;
        #2;
        check_val("midrst_count", 64'(count), 64'd0);
        check_val("midrst_dout_v", 64'(dout_v), 64'd0);
        check_val("midrst_din_r", 64'(din_r), 64'd0);
        sb_q.delete();
        set_in(1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic: mixed enable, valid and ready, with an occasional clear.
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(39) == 0);
            set_in($urandom_range(7) != 0, $urandom_range(1) == 1, $urandom, $urandom_range(2) != 0);
            cycle();
        end
        clr = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b1);
            cycle();
        end
        check_val("final_count", 64'(count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_elastic_fifo
